qracc_sram_arbiter: RTL and testbench

Two-requester arbiter that shares a single QRAcc SRAM bank request port (rq_wr_i / rq_valid_i / rq_ready_o / rd_valid_o / rd_data_o / wr_data_i / addr_i) between the weight-load path (requester 0) and the debug/readback path (requester 1). It performs round-robin arbitration with grant locking across back-pressure. It routes in-order read responses back to the issuing requester through an outstanding-read ID FIFO. It sits between the qracc_controller-driven requesters and the SRAM bank wrapper.

---
 rtl/qracc_sram_arbiter.sv | 139 +++++++++++++
 tb/tb_qracc_sram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_arbiter.sv
// Round-robin two-requester arbiter for one QRAcc SRAM bank port: grant locking across
// back-pressure, and an in-order read-ID FIFO that routes read data back to its issuer.
module qracc_sram_arbiter #(
    parameter  int unsigned numRows        = 128,
    parameter  int unsigned numCols        = 32,
    parameter  int unsigned maxOutstanding = 4,
    localparam int unsigned AW             = $clog2(numRows)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               r0_rq_valid_i,
    input  logic               r0_rq_wr_i,
    input  logic [AW-1:0]      r0_addr_i,
    input  logic [numCols-1:0] r0_wr_data_i,
    output logic               r0_rq_ready_o,
    output logic               r0_rd_valid_o,
    output logic [numCols-1:0] r0_rd_data_o,

    input  logic               r1_rq_valid_i,
    input  logic               r1_rq_wr_i,
    input  logic [AW-1:0]      r1_addr_i,
    input  logic [numCols-1:0] r1_wr_data_i,
    output logic               r1_rq_ready_o,
    output logic               r1_rd_valid_o,
    output logic [numCols-1:0] r1_rd_data_o,

    output logic               sram_rq_valid_o,
    output logic               sram_rq_wr_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [numCols-1:0] sram_wr_data_o,
    input  logic               sram_rq_ready_i,
    input  logic               sram_rd_valid_i,
    input  logic [numCols-1:0] sram_rd_data_i,

    output logic               busy_o,
    output logic               err_o
);
    localparam int unsigned PW = (maxOutstanding > 1) ? $clog2(maxOutstanding) : 1;
    localparam int unsigned CW = $clog2(maxOutstanding + 1);

    logic                      prio_q, prio_d;
    logic                      lock_q, lock_d;
    logic                      lock_id_q, lock_id_d;
    logic                      err_q, err_d;
    logic [maxOutstanding-1:0] id_q, id_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;

    logic fifo_full, fifo_empty;
    logic elig0, elig1;
    logic grant, handshake, push, pop, head;

    // Grant selection; fullness uses the registered count, so a same-cycle pop does not unblock a read.
    always_comb begin
        fifo_full  = (count_q == CW'(maxOutstanding));
        fifo_empty = (count_q == '0);
        elig0      = r0_rq_valid_i & (r0_rq_wr_i | ~fifo_full);
        elig1      = r1_rq_valid_i & (r1_rq_wr_i | ~fifo_full);
        grant      = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (elig0 && elig1) begin
            grant = prio_q;
        end else if (elig1) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        sram_rq_valid_o = grant ? elig1 : elig0;
        sram_rq_wr_o    = grant ? r1_rq_wr_i : r0_rq_wr_i;
        sram_addr_o     = grant ? r1_addr_i : r0_addr_i;
        sram_wr_data_o  = grant ? r1_wr_data_i : r0_wr_data_i;
        r0_rq_ready_o   = ~grant & elig0 & sram_rq_ready_i;
        r1_rq_ready_o   = grant & elig1 & sram_rq_ready_i;
        handshake       = sram_rq_valid_o & sram_rq_ready_i;
        push            = handshake & ~sram_rq_wr_o;
        pop             = sram_rd_valid_i & ~fifo_empty;
        head            = id_q[rd_ptr_q];
        r0_rd_valid_o   = pop & ~head;
        r1_rd_valid_o   = pop & head;
        r0_rd_data_o    = sram_rd_data_i;
        r1_rd_data_o    = sram_rd_data_i;
        busy_o          = lock_q | ~fifo_empty;
        err_o           = err_q;
    end

    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;
        id_d      = id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (handshake) begin
            prio_d = ~grant;
            lock_d = 1'b0;
        end else if (sram_rq_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
        if (push) begin
            id_d[wr_ptr_q] = grant;
            wr_ptr_d       = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (sram_rd_valid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            err_q     <= 1'b0;
            id_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
            id_q      <= id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Self-checking bench for qracc_sram_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration and response-routing rules.
module tb_qracc_sram_arbiter;
    localparam int unsigned NR = 128;
    localparam int unsigned NC = 32;
    localparam int unsigned MO = 4;
    localparam int unsigned AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_rq_valid_i, r0_rq_wr_i, r1_rq_valid_i, r1_rq_wr_i;
    logic [AW-1:0] r0_addr_i, r1_addr_i;
    logic [NC-1:0] r0_wr_data_i, r1_wr_data_i;
    logic          r0_rq_ready_o, r0_rd_valid_o, r1_rq_ready_o, r1_rd_valid_o;
    logic [NC-1:0] r0_rd_data_o, r1_rd_data_o;
    logic          sram_rq_valid_o, sram_rq_wr_o;
    logic [AW-1:0] sram_addr_o;
    logic [NC-1:0] sram_wr_data_o;
    logic          sram_rq_ready_i, sram_rd_valid_i;
    logic [NC-1:0] sram_rd_data_i;
    logic          busy_o, err_o;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: outstanding-read issuer queue plus arbitration bookkeeping.
    bit m_q[$];
    bit m_prio, m_lock, m_lock_id, m_err, m_g, m_pop;
    bit e_svalid, e_swr, e_rdy0, e_rdy1, e_rdv0, e_rdv1, e_busy, e_err;
    logic [AW-1:0] e_saddr;
    logic [NC-1:0] e_sdata;

    always #5 clk = ~clk;

    qracc_sram_arbiter #(.numRows(NR), .numCols(NC), .maxOutstanding(MO)) dut (
        .clk(clk), .rst(rst),
        .r0_rq_valid_i(r0_rq_valid_i), .r0_rq_wr_i(r0_rq_wr_i), .r0_addr_i(r0_addr_i),
        .r0_wr_data_i(r0_wr_data_i), .r0_rq_ready_o(r0_rq_ready_o),
        .r0_rd_valid_o(r0_rd_valid_o), .r0_rd_data_o(r0_rd_data_o),
        .r1_rq_valid_i(r1_rq_valid_i), .r1_rq_wr_i(r1_rq_wr_i), .r1_addr_i(r1_addr_i),
        .r1_wr_data_i(r1_wr_data_i), .r1_rq_ready_o(r1_rq_ready_o),
        .r1_rd_valid_o(r1_rd_valid_o), .r1_rd_data_o(r1_rd_data_o),
        .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o),
        .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o),
        .sram_rq_ready_i(sram_rq_ready_i), .sram_rd_valid_i(sram_rd_valid_i),
        .sram_rd_data_i(sram_rd_data_i), .busy_o(busy_o), .err_o(err_o)
    );

    function automatic void model_eval();
        bit full, el0, el1;
        full = (m_q.size() >= MO);
        el0  = r0_rq_valid_i && (r0_rq_wr_i || !full);
        el1  = r1_rq_valid_i && (r1_rq_wr_i || !full);
        if (m_lock)          m_g = m_lock_id;
        else if (el0 && el1) m_g = m_prio;
        else                 m_g = el1;
        e_svalid = m_g ? el1 : el0;
        e_swr    = m_g ? r1_rq_wr_i : r0_rq_wr_i;
        e_saddr  = m_g ? r1_addr_i : r0_addr_i;
        e_sdata  = m_g ? r1_wr_data_i : r0_wr_data_i;
        e_rdy0   = e_svalid && !m_g && sram_rq_ready_i;
        e_rdy1   = e_svalid && m_g && sram_rq_ready_i;
        m_pop    = sram_rd_valid_i && (m_q.size() > 0);
        e_rdv0   = m_pop && (m_q[0] == 1'b0);
        e_rdv1   = m_pop && (m_q[0] == 1'b1);
        e_busy   = m_lock || (m_q.size() > 0);
        e_err    = m_err;
    endfunction

    function automatic void model_commit();
        if (rst) begin
            m_prio = 0; m_lock = 0; m_lock_id = 0; m_err = 0;
            m_q.delete();
        end else begin
            if (sram_rd_valid_i && m_q.size() == 0) m_err = 1;
            if (m_pop) void'(m_q.pop_front());
            if (e_svalid && sram_rq_ready_i) begin
                m_prio = !m_g;
                m_lock = 0;
                if (!e_swr) m_q.push_back(m_g);
            end else if (e_svalid) begin
                m_lock    = 1;
                m_lock_id = m_g;
            end
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        r0_rq_valid_i = 0; r0_rq_wr_i = 0; r0_addr_i = '0; r0_wr_data_i = '0;
        r1_rq_valid_i = 0; r1_rq_wr_i = 0; r1_addr_i = '0; r1_wr_data_i = '0;
        sram_rq_ready_i = 0; sram_rd_valid_i = 0; sram_rd_data_i = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        settle(); advance();
        rst = 0;
        settle();
        n_cmp++; if (r0_rq_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_rdy0 got=%b exp=0", r0_rq_ready_o); end
        n_cmp++; if (r1_rq_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_rdy1 got=%b exp=0", r1_rq_ready_o); end
        n_cmp++; if (sram_rq_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_svalid got=%b exp=0", sram_rq_valid_o); end
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_rdv got=%b%b exp=00", r0_rd_valid_o, r1_rd_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err_o); end
        advance();
    endtask

    task automatic test_alternate();
        logic [NC-1:0] exp_d;
        idle();
        r0_rq_valid_i = 1; r0_addr_i = 7'd3;
        r1_rq_valid_i = 1; r1_addr_i = 7'd7;
        sram_rq_ready_i = 1;
        for (int k = 0; k < 9; k++) begin
            if (k == 8) begin r0_rq_valid_i = 0; r1_rq_valid_i = 0; end
            sram_rd_valid_i = (k > 0);
            exp_d = ((k - 1) % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
            sram_rd_data_i = exp_d;
            settle();
            if (k < 8) begin
                n_cmp++; if (sram_addr_o !== ((k % 2) ? 7'd7 : 7'd3)) begin n_fail++; $display("FAIL alt_addr k=%0d got=%0d", k, sram_addr_o); end
                n_cmp++; if (r0_rq_ready_o !== ((k % 2) == 0)) begin n_fail++; $display("FAIL alt_rdy0 k=%0d got=%b", k, r0_rq_ready_o); end
                n_cmp++; if (r1_rq_ready_o !== ((k % 2) == 1)) begin n_fail++; $display("FAIL alt_rdy1 k=%0d got=%b", k, r1_rq_ready_o); end
            end
            if (k > 0) begin
                n_cmp++; if (r0_rd_valid_o !== ((k - 1) % 2 == 0)) begin n_fail++; $display("FAIL alt_rdv0 k=%0d got=%b", k, r0_rd_valid_o); end
                n_cmp++; if (r1_rd_valid_o !== ((k - 1) % 2 == 1)) begin n_fail++; $display("FAIL alt_rdv1 k=%0d got=%b", k, r1_rd_valid_o); end
                n_cmp++; if ((((k - 1) % 2 == 0) ? r0_rd_data_o : r1_rd_data_o) !== exp_d) begin n_fail++; $display("FAIL alt_data k=%0d got=%h exp=%h", k, ((k - 1) % 2 == 0) ? r0_rd_data_o : r1_rd_data_o, exp_d); end
            end
            advance();
        end
        idle();
    endtask

    task automatic test_lock();
        idle();
        sram_rq_ready_i = 1;
        r0_rq_valid_i = 1; r0_rq_wr_i = 1; r0_addr_i = 7'h00;
        settle(); advance();
        r0_addr_i = 7'h11; r0_wr_data_i = 32'hDEADBEEF;
        sram_rq_ready_i = 0;
        settle();
        n_cmp++; if (sram_addr_o !== 7'h11) begin n_fail++; $display("FAIL lock_addr0 got=%h exp=11", sram_addr_o); end
        advance();
        r1_rq_valid_i = 1; r1_rq_wr_i = 0; r1_addr_i = 7'h22;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++; if (sram_addr_o !== 7'h11) begin n_fail++; $display("FAIL lock_addr c=%0d got=%h exp=11", c, sram_addr_o); end
            n_cmp++; if (r1_rq_ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_rdy1 c=%0d got=%b exp=0", c, r1_rq_ready_o); end
            n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL lock_busy c=%0d got=%b exp=1", c, busy_o); end
            advance();
        end
        sram_rq_ready_i = 1;
        settle();
        n_cmp++; if ({r0_rq_ready_o, r1_rq_ready_o} !== 2'b10) begin n_fail++; $display("FAIL lock_release got=%b%b exp=10", r0_rq_ready_o, r1_rq_ready_o); end
        n_cmp++; if (sram_wr_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lock_wdata got=%h exp=deadbeef", sram_wr_data_o); end
        advance();
        r0_rq_valid_i = 0;
        settle();
        n_cmp++; if (r1_rq_ready_o !== 1'b1 || sram_addr_o !== 7'h22) begin n_fail++; $display("FAIL lock_next got rdy1=%b addr=%h exp 1/22", r1_rq_ready_o, sram_addr_o); end
        advance();
        r1_rq_valid_i = 0; sram_rd_valid_i = 1; sram_rd_data_i = 32'h12345678;
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b01 || r1_rd_data_o !== 32'h12345678) begin n_fail++; $display("FAIL lock_resp got=%b%b %h exp=01 12345678", r0_rd_valid_o, r1_rd_valid_o, r1_rd_data_o); end
        advance();
        idle();
    endtask

    task automatic test_fifo_full();
        idle();
        sram_rq_ready_i = 1; r0_rq_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            r0_addr_i = 7'(i);
            settle();
            n_cmp++; if (r0_rq_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_fill i=%0d got=%b exp=1", i, r0_rq_ready_o); end
            advance();
        end
        r0_addr_i = 7'h40;
        r1_rq_valid_i = 1; r1_rq_wr_i = 1; r1_addr_i = 7'h55;
        settle();
        n_cmp++; if ({r0_rq_ready_o, r1_rq_ready_o} !== 2'b01) begin n_fail++; $display("FAIL full_wr got=%b%b exp=01", r0_rq_ready_o, r1_rq_ready_o); end
        n_cmp++; if (sram_addr_o !== 7'h55) begin n_fail++; $display("FAIL full_addr got=%h exp=55", sram_addr_o); end
        advance();
        r1_rq_valid_i = 0;
        settle();
        n_cmp++; if (sram_rq_valid_o !== 1'b0 || r0_rq_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_stall got=%b%b exp=00", sram_rq_valid_o, r0_rq_ready_o); end
        advance();
        sram_rd_valid_i = 1; sram_rd_data_i = 32'h0BADF00D;
        settle();
        n_cmp++; if (r0_rd_valid_o !== 1'b1 || r0_rd_data_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL full_pop got=%b %h exp=1 0badf00d", r0_rd_valid_o, r0_rd_data_o); end
        n_cmp++; if (r0_rq_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_samecyc got=%b exp=0", r0_rq_ready_o); end
        advance();
        sram_rd_valid_i = 0;
        settle();
        n_cmp++; if (r0_rq_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_retry got=%b exp=1", r0_rq_ready_o); end
        advance();
        r0_rq_valid_i = 0; sram_rd_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_cmp++; if (r0_rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_drain i=%0d got=%b exp=1", i, r0_rd_valid_o); end
            advance();
        end
        idle();
        settle();
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_idle busy got=%b exp=0", busy_o); end
        advance();
    endtask

    task automatic test_push_pop();
        idle();
        sram_rq_ready_i = 1;
        r0_rq_valid_i = 1; r0_addr_i = 7'd1;
        settle(); advance();
        r0_rq_valid_i = 0; r1_rq_valid_i = 1; r1_addr_i = 7'd2;
        settle(); advance();
        r1_rq_valid_i = 0; r0_rq_valid_i = 1; r0_addr_i = 7'd3;
        sram_rd_valid_i = 1; sram_rd_data_i = 32'hCAFE0001;
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b10) begin n_fail++; $display("FAIL pp_rdv got=%b%b exp=10", r0_rd_valid_o, r1_rd_valid_o); end
        n_cmp++; if (r0_rq_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_rdy0 got=%b exp=1", r0_rq_ready_o); end
        advance();
        idle();
        sram_rd_valid_i = 1;
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b01) begin n_fail++; $display("FAIL pp_second got=%b%b exp=01", r0_rd_valid_o, r1_rd_valid_o); end
        advance();
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b10) begin n_fail++; $display("FAIL pp_third got=%b%b exp=10", r0_rd_valid_o, r1_rd_valid_o); end
        advance();
        sram_rd_valid_i = 0;
        settle();
        n_cmp++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL pp_empty busy/err got=%b%b exp=00", busy_o, err_o); end
        advance();
    endtask

    task automatic test_err();
        idle();
        sram_rd_valid_i = 1; sram_rd_data_i = 32'h0000FFFF;
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b00) begin n_fail++; $display("FAIL err_rdv got=%b%b exp=00", r0_rd_valid_o, r1_rd_valid_o); end
        advance();
        sram_rd_valid_i = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky c=%0d got=%b exp=1", c, err_o); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        sram_rq_ready_i = 1;
        r0_rq_valid_i = 1; settle(); advance();
        r0_rq_valid_i = 0; r1_rq_valid_i = 1; settle(); advance();
        r1_rq_valid_i = 0; r0_rq_valid_i = 1; settle(); advance();
        r0_rq_valid_i = 0; r1_rq_valid_i = 1; r1_addr_i = 7'h33; sram_rq_ready_i = 0;
        settle(); advance();
        settle();
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre got=%b exp=1", busy_o); end
        rst = 1;
        advance();
        rst = 0; idle();
        settle();
        n_cmp++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_clear busy/err got=%b%b exp=00", busy_o, err_o); end
        advance();
        sram_rd_valid_i = 1;
        settle();
        n_cmp++; if ({r0_rd_valid_o, r1_rd_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_stale_rdv got=%b%b exp=00", r0_rd_valid_o, r1_rd_valid_o); end
        advance();
        sram_rd_valid_i = 0;
        r0_rq_valid_i = 1; r1_rq_valid_i = 1; sram_rq_ready_i = 1;
        settle();
        n_cmp++; if ({r0_rq_ready_o, r1_rq_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rmid_prio got=%b%b exp=10", r0_rq_ready_o, r1_rq_ready_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rmid_err got=%b exp=1", err_o); end
        advance();
        idle();
        rst = 1; settle(); advance();
        rst = 0;
    endtask

    task automatic test_random();
        bit p0 = 0, p1 = 0;
        idle();
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(2) != 0) begin
                p0 = 1; r0_rq_wr_i = 1'($urandom_range(1)); r0_addr_i = 7'($urandom); r0_wr_data_i = $urandom;
            end
            if (!p1 && $urandom_range(2) != 0) begin
                p1 = 1; r1_rq_wr_i = 1'($urandom_range(1)); r1_addr_i = 7'($urandom); r1_wr_data_i = $urandom;
            end
            r0_rq_valid_i   = p0;
            r1_rq_valid_i   = p1;
            sram_rq_ready_i = ($urandom_range(3) != 0);
            sram_rd_valid_i = (m_q.size() > 0) && ($urandom_range(1) == 1);
            sram_rd_data_i  = $urandom;
            settle();
            n_cmp++; if (sram_rq_valid_o !== e_svalid) begin n_fail++; $display("FAIL rnd_svalid c=%0d got=%b exp=%b", c, sram_rq_valid_o, e_svalid); end
            n_cmp++; if (r0_rq_ready_o !== e_rdy0) begin n_fail++; $display("FAIL rnd_rdy0 c=%0d got=%b exp=%b", c, r0_rq_ready_o, e_rdy0); end
            n_cmp++; if (r1_rq_ready_o !== e_rdy1) begin n_fail++; $display("FAIL rnd_rdy1 c=%0d got=%b exp=%b", c, r1_rq_ready_o, e_rdy1); end
            n_cmp++; if (r0_rd_valid_o !== e_rdv0) begin n_fail++; $display("FAIL rnd_rdv0 c=%0d got=%b exp=%b", c, r0_rd_valid_o, e_rdv0); end
            n_cmp++; if (r1_rd_valid_o !== e_rdv1) begin n_fail++; $display("FAIL rnd_rdv1 c=%0d got=%b exp=%b", c, r1_rd_valid_o, e_rdv1); end
            n_cmp++; if (busy_o !== e_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_o, e_busy); end
            n_cmp++; if (err_o !== e_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_o, e_err); end
            if (e_svalid) begin
                n_cmp++; if ({sram_rq_wr_o, sram_addr_o, sram_wr_data_o} !== {e_swr, e_saddr, e_sdata}) begin
                    n_fail++; $display("FAIL rnd_fields c=%0d got=%b/%h/%h exp=%b/%h/%h", c, sram_rq_wr_o, sram_addr_o, sram_wr_data_o, e_swr, e_saddr, e_sdata);
                end
            end
            if (e_rdv0 || e_rdv1) begin
                n_cmp++; if ((e_rdv0 ? r0_rd_data_o : r1_rd_data_o) !== sram_rd_data_i) begin
                    n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, e_rdv0 ? r0_rd_data_o : r1_rd_data_o, sram_rd_data_i);
                end
            end
            if (e_rdy0) p0 = 0;
            if (e_rdy1) p1 = 0;
            advance();
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alternate();
        test_lock();
        test_fifo_full();
        test_push_pop();
        test_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
